// File: rtl/hs_npu_pkg.sv
// hs_npu_pkg: shared types and helpers for the NPU memory-side blocks
package hs_npu_pkg;
  typedef logic [31:0] uword;
  localparam int unsigned MEM_WORDS = 2;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ISSUE, WR_WAIT} mem_arb_state_t;
  typedef struct packed {
    logic                   write;
    uword                   addr;
    logic [MEM_WORDS*32-1:0] wdata;
  } mem_req_t;
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/hs_npu_rr_arbiter.sv
// hs_npu_rr_arbiter: combinational round-robin pick of the first request at/after the pointer
module hs_npu_rr_arbiter #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o    = 1'b1;
        idx_o      = IW'(j);
        grant_o[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/hs_npu_mem_arbiter.sv
// hs_npu_mem_arbiter: round-robin sharing of the NPU memory interface, one transaction in flight,
// request held stable for the whole transfer and read data routed back to the granted requester.
module hs_npu_mem_arbiter
  import hs_npu_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int WORDS  = 2,
  parameter int ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ-1:0]          req_write_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*WORDS*32-1:0] req_wdata_i,
  output logic [N_REQ-1:0]          req_ack_o,
  output logic [N_REQ-1:0]          rsp_valid_o,
  output logic [WORDS*32-1:0]       rsp_rdata_o,
  input  logic                      flush_i,
  input  logic                      mif_ready_i,
  input  logic                      mif_valid_i,
  input  logic [WORDS*32-1:0]       mif_rdata_i,
  output logic                      mif_read_o,
  output logic                      mif_write_o,
  output logic                      mif_invalidate_o,
  output logic [ADDR_W-1:0]         mif_addr_o,
  output logic [WORDS*32-1:0]       mif_wdata_o
);
  localparam int IW = $clog2(N_REQ);
  localparam int DW = WORDS * 32;
  mem_arb_state_t   r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_gnt;
  logic             r_wr_armed;
  logic [ADDR_W-1:0] r_addr;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_rdata;
  logic [N_REQ-1:0] r_rsp;
  logic [N_REQ-1:0] w_onehot;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic             w_take;
  hs_npu_rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (r_ptr),
    .grant_o (w_onehot),
    .idx_o   (w_idx),
    .valid_o (w_any)
  );
  assign w_take           = rst_n && r_state == IDLE && w_any && mif_ready_i && !flush_i;
  assign req_ack_o        = w_take ? w_onehot : '0;
  // read drops on the completion cycle so the interface does not start a second burst
  assign mif_read_o       = r_state == RD_WAIT && !mif_valid_i && !flush_i;
  assign mif_invalidate_o = r_state == RD_WAIT && flush_i;
  assign mif_write_o      = r_state == WR_ISSUE;
  assign mif_addr_o       = r_addr;
  assign mif_wdata_o      = r_wdata;
  assign rsp_valid_o      = r_rsp;
  assign rsp_rdata_o      = r_rdata;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_wr_armed <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_rsp      <= '0;
    end else begin
      r_rsp <= '0;
      case (r_state)
        IDLE: if (w_take) begin
          r_gnt   <= w_idx;
          r_addr  <= req_addr_i[w_idx*ADDR_W +: ADDR_W];
          r_wdata <= req_wdata_i[w_idx*DW +: DW];
          r_ptr   <= IW'(rr_next(int'(w_idx), N_REQ));
          r_state <= req_write_i[w_idx] ? WR_ISSUE : RD_WAIT;
        end
        RD_WAIT: if (flush_i) r_state <= IDLE;
        else if (mif_valid_i) begin
          r_rdata <= mif_rdata_i;
          r_rsp   <= N_REQ'(1) << r_gnt;
          r_state <= IDLE;
        end
        WR_ISSUE: begin
          r_wr_armed <= 1'b0;
          r_state    <= WR_WAIT;
        end
        // the interface's ready lags the write strobe by a cycle
        WR_WAIT: if (!r_wr_armed) r_wr_armed <= 1'b1;
        else if (mif_ready_i) begin
          r_rsp   <= N_REQ'(1) << r_gnt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hs_npu_mem_arbiter.sv
// tb_hs_npu_mem_arbiter: directed scenarios for the memory arbiter with a hand-driven interface
module tb_hs_npu_mem_arbiter;
  localparam int N = 3;
  localparam int DW = 64;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] req_valid = '0, req_write = '0, ack, rsp;
  logic [N*32-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] rsp_rdata, mif_rdata = '0, mif_wdata;
  logic flush = 0, mif_ready = 1, mif_valid = 0, mif_read, mif_write, mif_inval;
  logic [31:0] mif_addr;
  int errors = 0, checks = 0, rd_starts = 0, wr_cycles = 0;
  logic prev_rd = 0;

  hs_npu_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_ack_o(ack), .rsp_valid_o(rsp),
    .rsp_rdata_o(rsp_rdata), .flush_i(flush), .mif_ready_i(mif_ready), .mif_valid_i(mif_valid),
    .mif_rdata_i(mif_rdata), .mif_read_o(mif_read), .mif_write_o(mif_write),
    .mif_invalidate_o(mif_inval), .mif_addr_o(mif_addr), .mif_wdata_o(mif_wdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && mif_read && !prev_rd) rd_starts++;
    if (rst_n && mif_write) wr_cycles++;
    prev_rd = mif_read;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; req_valid = '0; req_write = '0; flush = 0; mif_valid = 0; mif_ready = 1; mif_rdata = '0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic wait_ack(output int idx);
    idx = -1;
    for (int c = 0; c < 8 && idx < 0; c++) begin
      #1;
      for (int i = 0; i < N; i++) if (ack[i]) idx = i;
      if (idx < 0) tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if ({ack, rsp, mif_read, mif_write, mif_inval} !== '0) begin errors++; $display("FAIL reset_ctrl: got %b exp 0", {ack, rsp, mif_read, mif_write, mif_inval}); end
    checks++; if (mif_addr !== 32'h0 || mif_wdata !== '0 || rsp_rdata !== '0) begin errors++; $display("FAIL reset_regs: addr %h wdata %h rdata %h exp 0", mif_addr, mif_wdata, rsp_rdata); end
  endtask

  task automatic test_single_read();
    int s;
    do_reset();
    s = rd_starts;
    req_valid = 3'b001; req_addr[31:0] = 32'h100;
    #1;
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL rd_ack: got %b exp 001", ack); end
    tick(); req_valid = '0; mif_ready = 0; #1;
    checks++; if (mif_read !== 1'b1 || ack !== 3'b000 || mif_addr !== 32'h100) begin errors++; $display("FAIL rd_issue: read %b ack %b addr %h exp 1 000 100", mif_read, ack, mif_addr); end
    repeat (2) begin
      tick();
      checks++; if (mif_read !== 1'b1 || rsp !== 3'b000) begin errors++; $display("FAIL rd_hold: read %b rsp %b exp 1 000", mif_read, rsp); end
    end
    tick(); mif_valid = 1; mif_rdata = {32'hB, 32'hA}; #1;
    checks++; if (mif_read !== 1'b0) begin errors++; $display("FAIL rd_drop: got %b exp 0", mif_read); end
    tick(); mif_valid = 0; mif_ready = 1; #1;
    checks++; if (rsp !== 3'b001 || rsp_rdata !== {32'hB, 32'hA}) begin errors++; $display("FAIL rd_rsp: rsp %b rdata %h exp 001 0000000b0000000a", rsp, rsp_rdata); end
    tick();
    checks++; if (rsp !== 3'b000) begin errors++; $display("FAIL rd_rsp_pulse: got %b exp 000", rsp); end
    checks++; if (rd_starts - s !== 1) begin errors++; $display("FAIL rd_count: got %0d exp 1", rd_starts - s); end
  endtask

  task automatic test_round_robin();
    int idx;
    do_reset();
    req_valid = 3'b111; req_write = '0;
    for (int t = 0; t < 6; t++) begin
      wait_ack(idx);
      checks++; if (idx !== t % 3 || $countones(ack) != 1) begin errors++; $display("FAIL rr_order%0d: got idx %0d ack %b exp %0d", t, idx, ack, t % 3); end
      tick(); mif_ready = 0; #1;
      checks++; if (rsp !== 3'b000 || ack !== 3'b000 || mif_read !== 1'b1) begin errors++; $display("FAIL rr_busy%0d: rsp %b ack %b read %b exp 000 000 1", t, rsp, ack, mif_read); end
      mif_valid = 1; mif_rdata = DW'(t + 1);
      tick(); mif_valid = 0; mif_ready = 1;
      checks++; if (rsp !== 3'(1 << (t % 3)) || rsp_rdata !== DW'(t + 1)) begin errors++; $display("FAIL rr_rsp%0d: rsp %b rdata %h exp %b %h", t, rsp, rsp_rdata, 3'(1 << (t % 3)), DW'(t + 1)); end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_write();
    int s;
    do_reset();
    s = wr_cycles;
    req_valid = 3'b010; req_write = 3'b010; req_addr[63:32] = 32'h200; req_wdata[127:64] = {32'h22, 32'h11};
    #1;
    checks++; if (ack !== 3'b010 || mif_write !== 1'b0) begin errors++; $display("FAIL wr_ack: ack %b write %b exp 010 0", ack, mif_write); end
    tick(); req_valid = '0; req_addr = '1; req_wdata = '1; #1;
    checks++; if (mif_write !== 1'b1 || mif_addr !== 32'h200 || mif_wdata !== {32'h22, 32'h11}) begin errors++; $display("FAIL wr_issue: write %b addr %h wdata %h exp 1 200 0000002200000011", mif_write, mif_addr, mif_wdata); end
    tick(); mif_ready = 1; #1;
    checks++; if (mif_write !== 1'b0 || rsp !== 3'b000) begin errors++; $display("FAIL wr_first_wait: write %b rsp %b exp 0 000", mif_write, rsp); end
    tick(); mif_ready = 0; flush = 1; #1;
    checks++; if (mif_inval !== 1'b0 || rsp !== 3'b000) begin errors++; $display("FAIL wr_flush_ignored: inval %b rsp %b exp 0 000", mif_inval, rsp); end
    tick(); flush = 0; #1;
    checks++; if (rsp !== 3'b000 || mif_addr !== 32'h200) begin errors++; $display("FAIL wr_busy: rsp %b addr %h exp 000 200", rsp, mif_addr); end
    tick(); mif_ready = 1; #1;
    checks++; if (rsp !== 3'b000 || mif_wdata !== {32'h22, 32'h11}) begin errors++; $display("FAIL wr_hold: rsp %b wdata %h exp 000 0000002200000011", rsp, mif_wdata); end
    tick();
    checks++; if (rsp !== 3'b010) begin errors++; $display("FAIL wr_rsp: got %b exp 010", rsp); end
    tick();
    checks++; if (rsp !== 3'b000 || wr_cycles - s !== 1) begin errors++; $display("FAIL wr_once: rsp %b write cycles %0d exp 000 1", rsp, wr_cycles - s); end
    req_write = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 3'b001; req_addr[31:0] = 32'h300;
    #1;
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL fl_ack: got %b exp 001", ack); end
    tick(); req_valid = '0; mif_ready = 0;
    tick(); flush = 1; #1;
    checks++; if (mif_inval !== 1'b1 || mif_read !== 1'b0) begin errors++; $display("FAIL fl_inval: inval %b read %b exp 1 0", mif_inval, mif_read); end
    tick(); flush = 0; #1;
    checks++; if (mif_inval !== 1'b0 || rsp !== 3'b000 || mif_read !== 1'b0) begin errors++; $display("FAIL fl_idle: inval %b rsp %b read %b exp 0 000 0", mif_inval, rsp, mif_read); end
    mif_ready = 1; req_valid = 3'b100; #1;
    checks++; if (ack !== 3'b100) begin errors++; $display("FAIL fl_next_ack: got %b exp 100", ack); end
    tick(); req_valid = '0; mif_ready = 0; mif_valid = 1; mif_rdata = 64'h55; #1;
    checks++; if (mif_read !== 1'b0) begin errors++; $display("FAIL fl_next_drop: got %b exp 0", mif_read); end
    tick(); mif_valid = 0; mif_ready = 1;
    checks++; if (rsp !== 3'b100 || rsp_rdata !== 64'h55) begin errors++; $display("FAIL fl_next_rsp: rsp %b rdata %h exp 100 55", rsp, rsp_rdata); end
  endtask

  task automatic test_flush_vs_valid();
    do_reset();
    req_valid = 3'b001; req_addr[31:0] = 32'h500;
    #1;
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL fv_ack: got %b exp 001", ack); end
    tick(); req_valid = '0; mif_ready = 0; flush = 1; mif_valid = 1; mif_rdata = 64'hDEAD; #1;
    checks++; if (mif_inval !== 1'b1) begin errors++; $display("FAIL fv_inval: got %b exp 1", mif_inval); end
    tick(); flush = 0; mif_valid = 0;
    checks++; if (rsp !== 3'b000 || rsp_rdata !== '0) begin errors++; $display("FAIL fv_discard: rsp %b rdata %h exp 000 0", rsp, rsp_rdata); end
    mif_ready = 1; req_valid = 3'b111; #1;
    checks++; if (ack !== 3'b010) begin errors++; $display("FAIL fv_ptr: got %b exp 010", ack); end
    tick(); req_valid = '0; mif_ready = 0; mif_valid = 1;
    tick(); mif_valid = 0; mif_ready = 1;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    req_valid = 3'b100; req_write = 3'b100; req_addr[95:64] = 32'h400; req_wdata[191:128] = 64'h1234;
    #1;
    checks++; if (ack !== 3'b100) begin errors++; $display("FAIL mr_ack: got %b exp 100", ack); end
    tick(); req_valid = '0; req_write = '0;
    tick(); rst_n = 0;
    tick(); rst_n = 1; mif_ready = 1; #1;
    checks++; if ({ack, rsp, mif_read, mif_write, mif_inval} !== '0 || mif_addr !== 32'h0 || mif_wdata !== '0) begin errors++; $display("FAIL mr_zero: ctrl %b addr %h wdata %h exp 0 0 0", {ack, rsp, mif_read, mif_write, mif_inval}, mif_addr, mif_wdata); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (rsp !== 3'b000) begin errors++; $display("FAIL mr_no_rsp%0d: got %b exp 000", c, rsp); end
    end
    req_valid = 3'b111; #1;
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL mr_ptr: got %b exp 001", ack); end
    tick(); req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_flush();
    test_flush_vs_valid();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
